video_timing_ctrl: RTL



---
 rtl/video_timing_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/video_timing_ctrl.sv
// Pixel-clock timing generator: raster counters, fixed-latency pixel request handshake,
// and registered colour/blanking/sync outputs for the TMDS channel encoders.
module video_timing_ctrl #(
  parameter int unsigned H_ACTIVE         = 640,
  parameter int unsigned H_FP             = 16,
  parameter int unsigned H_SYNC           = 96,
  parameter int unsigned H_BP             = 48,
  parameter int unsigned V_ACTIVE         = 480,
  parameter int unsigned V_FP             = 10,
  parameter int unsigned V_SYNC           = 2,
  parameter int unsigned V_BP             = 33,
  parameter bit          SYNC_ACTIVE_HIGH = 1'b0,
  parameter logic [23:0] FILL_RGB         = 24'hFF00FF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  output logic        rgb_req_o,
  output logic [11:0] x_o,
  output logic [11:0] y_o,
  input  logic [23:0] rgb_in_i,
  input  logic        rgb_valid_i,
  output logic [7:0]  red_o,
  output logic [7:0]  green_o,
  output logic [7:0]  blue_o,
  output logic        blanking_o,
  output logic        c0_o,
  output logic        c1_o,
  output logic        frame_start_o,
  output logic        underflow_o
);

  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HSyncStart = H_ACTIVE + H_FP;
  localparam int unsigned HSyncEnd   = HSyncStart + H_SYNC;
  localparam int unsigned VSyncStart = V_ACTIVE + V_FP;
  localparam int unsigned VSyncEnd   = VSyncStart + V_SYNC;
  localparam logic        SyncOn     = SYNC_ACTIVE_HIGH;
  localparam logic        SyncOff    = !SYNC_ACTIVE_HIGH;

  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_total_check
    $error("video_timing_ctrl: H_TOTAL and V_TOTAL must not exceed 4096");
  end

  // Raster counters
  logic [11:0] hcnt_q, hcnt_d;
  logic [11:0] vcnt_q, vcnt_d;

  // Request stage (cycle N)
  logic        req_q, req_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        fs_q, fs_d;

  // Response stage (cycle N+1): carries request-side flags alongside the source response
  logic        req1_q, hs1_q, vs1_q, fs1_q;

  // Output stage (cycle N+2)
  logic [23:0] rgb_q, rgb_d;
  logic        blank_q, blank_d;
  logic        c0_q, c0_d;
  logic        c1_q, c1_d;
  logic        fso_q, fso_d;
  logic        uf_q, uf_d;

  logic in_h_active, in_v_active, in_hsync, in_vsync;

  always_comb begin
    in_h_active = 32'(hcnt_q) < H_ACTIVE;
    in_v_active = 32'(vcnt_q) < V_ACTIVE;
    in_hsync    = (32'(hcnt_q) >= HSyncStart) && (32'(hcnt_q) < HSyncEnd);
    in_vsync    = (32'(vcnt_q) >= VSyncStart) && (32'(vcnt_q) < VSyncEnd);

    // Disabled: park at the frame origin so re-enable restarts at (0,0)
    hcnt_d = '0;
    vcnt_d = '0;
    if (enable_i) begin
      if (32'(hcnt_q) == H_TOTAL - 1) begin
        hcnt_d = '0;
        vcnt_d = (32'(vcnt_q) == V_TOTAL - 1) ? '0 : vcnt_q + 12'd1;
      end else begin
        hcnt_d = hcnt_q + 12'd1;
        vcnt_d = vcnt_q;
      end
    end

    req_d = enable_i & in_h_active & in_v_active;
    x_d   = req_d ? hcnt_q : x_q;
    y_d   = req_d ? vcnt_q : y_q;
    hs_d  = enable_i & in_hsync;
    vs_d  = enable_i & in_vsync;
    fs_d  = req_d & (hcnt_q == '0) & (vcnt_q == '0);
  end

  always_comb begin
    rgb_d   = '0;
    blank_d = ~req1_q;
    c0_d    = hs1_q ? SyncOn : SyncOff;
    c1_d    = vs1_q ? SyncOn : SyncOff;
    fso_d   = fs1_q;
    if (req1_q) begin
      rgb_d = rgb_valid_i ? rgb_in_i : FILL_RGB;
    end
    // A fresh underflow on the frame's first pixel outranks the frame-start clear
    uf_d = (req1_q & ~rgb_valid_i) | (uf_q & ~fs1_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      req_q  <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      req_q  <= req_d;
      x_q    <= x_d;
      y_q    <= y_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      fs_q   <= fs_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req1_q <= 1'b0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      fs1_q  <= 1'b0;
    end else begin
      req1_q <= req_q;
      hs1_q  <= hs_q;
      vs1_q  <= vs_q;
      fs1_q  <= fs_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rgb_q   <= '0;
      blank_q <= 1'b1;
      c0_q    <= SyncOff;
      c1_q    <= SyncOff;
      fso_q   <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      blank_q <= blank_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      fso_q   <= fso_d;
      uf_q    <= uf_d;
    end
  end

  assign rgb_req_o     = req_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign red_o         = rgb_q[23:16];
  assign green_o       = rgb_q[15:8];
  assign blue_o        = rgb_q[7:0];
  assign blanking_o    = blank_q;
  assign c0_o          = c0_q;
  assign c1_o          = c1_q;
  assign frame_start_o = fso_q;
  assign underflow_o   = uf_q;

endmodule
